// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/execute memory port arbiter.
// Imported by the arbiter top and its ISSUE-cycle timer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_EX = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/mem_arb_timer.sv
// Counts ISSUE cycles and flags the cycle in which the ack wait runs out.
// Cleared outside ISSUE so every transaction starts from zero.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // High during the TIMEOUT-th ISSUE cycle, so ISSUE lasts TIMEOUT cycles.
    assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch (reads) and execute (loads/stores),
// execute first with a starvation guard for fetch and an ack timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_readReq,
    input  logic [7:0]  if_addr,
    output logic [15:0] if_value,
    output logic        if_valueReady,
    input  logic        ex_readReq,
    input  logic        ex_writeReq,
    input  logic [7:0]  ex_addr,
    input  logic [15:0] ex_wdata,
    output logic [15:0] ex_rdata,
    output logic        ex_valueReady,
    output logic        ex_writeDone,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_readReq,
    output logic        mem_writeReq,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valueReady,
    output logic        grant_owner,
    output logic        busy,
    output logic        timeout_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t         state;
    state_t         nextState;
    logic [SW-1:0]  starveCnt;
    logic           isWrite;
    logic           exReq;
    logic           grantIf;
    logic           grantEx;
    logic           wrSel;
    logic           issueDone;
    logic           expired;
    logic           timerEn;
    logic           timerClr;
    logic [15:0]    respData;

    // Fetch only beats a pending execute once it has been passed over enough.
    always_comb begin
        exReq   = ex_readReq | ex_writeReq;
        grantIf = if_readReq && (!exReq || starveCnt == STARVE_MAX);
        grantEx = exReq && !grantIf;
        wrSel   = grantEx && ex_writeReq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            S_IDLE:  if (grantIf || grantEx) nextState = S_ISSUE;
            S_ISSUE: if (issueDone) nextState = S_RESP;
            S_RESP:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        timerEn   = (state == S_ISSUE);
        timerClr  = (state != S_ISSUE);
        issueDone = timerEn && (mem_valueReady || expired);
        respData  = mem_valueReady ? mem_rdata : 16'h0000;
    end

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .rst    (rst),
        .enable (timerEn),
        .clear  (timerClr),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt     <= '0;
            isWrite       <= 1'b0;
            grant_owner   <= OWN_IF;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_readReq   <= 1'b0;
            mem_writeReq  <= 1'b0;
            if_value      <= '0;
            if_valueReady <= 1'b0;
            ex_rdata      <= '0;
            ex_valueReady <= 1'b0;
            ex_writeDone  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            if_valueReady <= 1'b0;
            ex_valueReady <= 1'b0;
            ex_writeDone  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grantIf || grantEx) begin
                        grant_owner  <= grantEx ? OWN_EX : OWN_IF;
                        isWrite      <= wrSel;
                        mem_addr     <= grantEx ? ex_addr : if_addr;
                        mem_wdata    <= wrSel ? ex_wdata : 16'h0000;
                        mem_readReq  <= !wrSel;
                        mem_writeReq <= wrSel;
                    end
                    if (!if_readReq || grantIf) begin
                        starveCnt <= '0;
                    end else if (grantEx) begin
                        starveCnt <= starveCnt + SW'(1);
                    end
                end
                S_ISSUE: begin
                    if (issueDone) begin
                        mem_readReq  <= 1'b0;
                        mem_writeReq <= 1'b0;
                        if (!mem_valueReady) begin
                            timeout_err <= 1'b1;
                        end
                        if (isWrite) begin
                            ex_writeDone <= 1'b1;
                        end else if (grant_owner == OWN_EX) begin
                            ex_rdata      <= respData;
                            ex_valueReady <= 1'b1;
                        end else begin
                            if_value      <= respData;
                            if_valueReady <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_readReq;
    logic [7:0]  if_addr;
    logic [15:0] if_value;
    logic        if_valueReady;
    logic        ex_readReq;
    logic        ex_writeReq;
    logic [7:0]  ex_addr;
    logic [15:0] ex_wdata;
    logic [15:0] ex_rdata;
    logic        ex_valueReady;
    logic        ex_writeDone;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_readReq;
    logic        mem_writeReq;
    logic [15:0] mem_rdata;
    logic        mem_valueReady;
    logic        grant_owner;
    logic        busy;
    logic        timeout_err;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_readReq    (if_readReq),
        .if_addr       (if_addr),
        .if_value      (if_value),
        .if_valueReady (if_valueReady),
        .ex_readReq    (ex_readReq),
        .ex_writeReq   (ex_writeReq),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .ex_rdata      (ex_rdata),
        .ex_valueReady (ex_valueReady),
        .ex_writeDone  (ex_writeDone),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_readReq   (mem_readReq),
        .mem_writeReq  (mem_writeReq),
        .mem_rdata     (mem_rdata),
        .mem_valueReady(mem_valueReady),
        .grant_owner   (grant_owner),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic expOwn [6];
        int   n;
        expOwn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        if_readReq = 1'b0;
        if_addr = 8'h00;
        ex_readReq = 1'b0;
        ex_writeReq = 1'b0;
        ex_addr = 8'h00;
        ex_wdata = 16'h0000;
        mem_rdata = 16'h0000;
        mem_valueReady = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdreq", mem_readReq, 0);
        chk("rst_wrreq", mem_writeReq, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_exrdata", ex_rdata, 0);
        rst = 1'b1;

        // Ack in IDLE is ignored
        mem_valueReady = 1'b1;
        @(negedge clk);
        mem_valueReady = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_exvr", ex_valueReady, 0);

        // Execute load, ack on the second ISSUE cycle
        ex_readReq = 1'b1;
        ex_addr = 8'h10;
        @(negedge clk);
        ex_readReq = 1'b0;
        chk("ld_rdreq", mem_readReq, 1);
        chk("ld_addr", mem_addr, 8'h10);
        chk("ld_owner", grant_owner, 1);
        chk("ld_busy", busy, 1);
        @(negedge clk);
        mem_valueReady = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_valueReady = 1'b0;
        chk("ld_exvr", ex_valueReady, 1);
        chk("ld_exrdata", ex_rdata, 16'hBEEF);
        chk("ld_ifvr", if_valueReady, 0);
        chk("ld_strobe_off", mem_readReq, 0);
        @(negedge clk);
        chk("ld_exvr_1cyc", ex_valueReady, 0);
        chk("ld_idle", busy, 0);
        chk("ld_hold", ex_rdata, 16'hBEEF);

        // Fetch, address changes during ISSUE
        if_readReq = 1'b1;
        if_addr = 8'h20;
        @(negedge clk);
        chk("if_addr", mem_addr, 8'h20);
        chk("if_owner", grant_owner, 0);
        if_addr = 8'h33;
        if_readReq = 1'b0;
        @(negedge clk);
        chk("if_addr_stable", mem_addr, 8'h20);
        mem_valueReady = 1'b1;
        mem_rdata = 16'hCAFE;
        @(negedge clk);
        mem_valueReady = 1'b0;
        chk("if_vr", if_valueReady, 1);
        chk("if_value", if_value, 16'hCAFE);
        chk("if_exvr", ex_valueReady, 0);
        chk("if_exrdata_hold", ex_rdata, 16'hBEEF);
        @(negedge clk);

        // Store and load together: store first
        ex_writeReq = 1'b1;
        ex_readReq = 1'b1;
        ex_wdata = 16'h1234;
        ex_addr = 8'h44;
        @(negedge clk);
        chk("st_wrreq", mem_writeReq, 1);
        chk("st_rdreq", mem_readReq, 0);
        chk("st_wdata", mem_wdata, 16'h1234);
        ex_writeReq = 1'b0;
        mem_valueReady = 1'b1;
        mem_rdata = 16'h7777;
        @(negedge clk);
        mem_valueReady = 1'b0;
        chk("st_done", ex_writeDone, 1);
        chk("st_exvr", ex_valueReady, 0);
        chk("st_rdata_hold", ex_rdata, 16'hBEEF);
        @(negedge clk);
        chk("st_done_1cyc", ex_writeDone, 0);
        chk("st_idle", busy, 0);
        @(negedge clk);
        chk("ld2_rdreq", mem_readReq, 1);
        chk("ld2_wrreq", mem_writeReq, 0);
        ex_readReq = 1'b0;
        mem_valueReady = 1'b1;
        mem_rdata = 16'h5555;
        @(negedge clk);
        mem_valueReady = 1'b0;
        chk("ld2_rdata", ex_rdata, 16'h5555);
        @(negedge clk);

        // Starvation: both held, expect EX,EX,EX,EX,IF,EX
        if_readReq = 1'b1;
        ex_readReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("starve_own%0d", i), grant_owner, expOwn[i]);
            mem_valueReady = 1'b1;
            @(negedge clk);
            mem_valueReady = 1'b0;
            @(negedge clk);
        end
        if_readReq = 1'b0;
        ex_readReq = 1'b0;
        @(negedge clk);

        // Timeout: no ack
        if_readReq = 1'b1;
        if_addr = 8'h55;
        @(negedge clk);
        if_readReq = 1'b0;
        n = 0;
        while (mem_readReq && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_vr", if_valueReady, 1);
        chk("tmo_data", if_value, 16'h0000);
        chk("tmo_err", timeout_err, 1);
        @(negedge clk);
        chk("tmo_vr_1cyc", if_valueReady, 0);
        @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);

        // Asynchronous reset mid-ISSUE
        ex_readReq = 1'b1;
        ex_addr = 8'h66;
        @(negedge clk);
        chk("ar_rdreq", mem_readReq, 1);
        ex_readReq = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_rdreq_off", mem_readReq, 0);
        chk("ar_busy", busy, 0);
        chk("ar_tmo", timeout_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_exvr", ex_valueReady, 0);
        chk("ar_ifvr", if_valueReady, 0);
        chk("ar_idle", busy, 0);
        @(negedge clk);
        chk("ar_exvr2", ex_valueReady, 0);
        chk("ar_exrdata", ex_rdata, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
